// File: rtl/video_func_switcher.sv
// video_func_switcher
// Selects which of NUM_FUNC video functions drives the display. A switch
// request is latched in IDLE, committed on the next frame_start, and then
// followed by BLANK_FRAMES black frames. The pixel path is a two-stage
// pipeline. The function index that issued an address also selects the
// colour for that address, so one pixel never mixes sources.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid, req_func switch request strobe and requested function index
//   req_ready           high while idle (able to accept a request)
//   req_err             one-cycle pulse after an out-of-range request
//   frame_start         one-cycle pulse at each frame start
//   display_addr        pixel address from the timing generator
//   addr_valid          display_addr is an active pixel
//   func_color          flattened colours, function i at [i*COLOR_W +: COLOR_W]
//   func_addr, func_en  registered address broadcast and one-hot owner enable
//   display_color       registered colour to the DAC
//   active_func         currently committed function
//   switching           high while a switch is pending or blanking
module video_func_switcher #(
    parameter int unsigned NUM_FUNC     = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned COLOR_W      = 3,
    parameter int unsigned BLANK_FRAMES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [SEL_W-1:0]            req_func,
    output logic                        req_ready,
    output logic                        req_err,
    input  logic                        frame_start,
    input  logic [ADDR_W-1:0]           display_addr,
    input  logic                        addr_valid,
    input  logic [NUM_FUNC*COLOR_W-1:0] func_color,
    output logic [ADDR_W-1:0]           func_addr,
    output logic [NUM_FUNC-1:0]         func_en,
    output logic [COLOR_W-1:0]          display_color,
    output logic [SEL_W-1:0]            active_func,
    output logic                        switching
);

    localparam int unsigned CNT_W = 4;
    localparam logic [SEL_W:0] NUM_FUNC_V = (SEL_W + 1)'(NUM_FUNC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   pend_func, pend_nxt;
    logic [SEL_W-1:0]   active_nxt;
    logic [CNT_W-1:0]   blank_cnt, cnt_nxt;
    logic               req_err_nxt;
    logic               req_in_range;

    // Pipeline stage-1 side copies that travel with func_addr/func_en
    logic [SEL_W-1:0]   s1_sel;
    logic               s1_valid;
    logic               s1_blank;
    logic [COLOR_W-1:0] color_mux;

    assign req_in_range = ({1'b0, req_func} < NUM_FUNC_V);

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend_func   <= '0;
            active_func <= '0;
            blank_cnt   <= '0;
            req_err     <= 1'b0;
            req_ready   <= 1'b1;
            switching   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_func   <= pend_nxt;
            active_func <= active_nxt;
            blank_cnt   <= cnt_nxt;
            req_err     <= req_err_nxt;
            req_ready   <= (state_nxt == IDLE);
            switching   <= (state_nxt != IDLE);
        end
    end

    // Next-state logic; a frame_start seen while still IDLE never commits
    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend_func;
        active_nxt  = active_func;
        cnt_nxt     = blank_cnt;
        req_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!req_in_range) begin
                        req_err_nxt = 1'b1;
                    end else if (req_func != active_func) begin
                        pend_nxt  = req_func;
                        state_nxt = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frame_start) begin
                    active_nxt = pend_func;
                    cnt_nxt    = CNT_W'(BLANK_FRAMES);
                    state_nxt  = (BLANK_FRAMES == 0) ? IDLE : BLANK;
                end
            end
            BLANK: begin
                if (frame_start) begin
                    if (blank_cnt <= CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = blank_cnt - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: broadcast address and owner enable, capture sel/valid/blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_addr <= '0;
            func_en   <= '0;
            s1_sel    <= '0;
            s1_valid  <= 1'b0;
            s1_blank  <= 1'b0;
        end else begin
            func_addr <= display_addr;
            func_en   <= addr_valid ? (NUM_FUNC'(1) << active_func) : '0;
            s1_sel    <= active_func;
            s1_valid  <= addr_valid;
            s1_blank  <= (state == BLANK);
        end
    end

    // Colour slice chosen by the index that issued the stage-1 address
    always_comb begin
        color_mux = '0;
        for (int unsigned i = 0; i < NUM_FUNC; i++) begin
            if (s1_sel == SEL_W'(i)) begin
                color_mux = func_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage 2: colour to the DAC, black during blank frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_color <= '0;
        end else begin
            display_color <= (s1_valid && !s1_blank) ? color_mux : '0;
        end
    end

endmodule

// File: doc/video_func_switcher.md
VIDEO_FUNC_SWITCHER -- requirements
Module: video_func_switcher

Interface
REQ-001 SHALL have parameter NUM_FUNC, default 4, number of selectable video functions (2..16).
REQ-002 SHALL have parameter SEL_W, default 2, function-index width (SEL_W >= clog2(NUM_FUNC)).
REQ-003 SHALL have parameter ADDR_W, default 20, pixel-address width.
REQ-004 SHALL have parameter COLOR_W, default 3, pixel-colour width.
REQ-005 SHALL have parameter BLANK_FRAMES, default 1, black frames inserted after a switch (0..15).
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid  in  1  switch request strobe.
REQ-009 SHALL have port req_func  in  SEL_W  requested function index.
REQ-010 SHALL have port req_ready  out  1  high only in IDLE.
REQ-011 SHALL have port req_err  out  1  one-cycle pulse on rejected request.
REQ-012 SHALL have port frame_start  in  1  one-cycle pulse at each frame start.
REQ-013 SHALL have port display_addr  in  ADDR_W  pixel address from timing generator.
REQ-014 SHALL have port addr_valid  in  1  display_addr is an active pixel.
REQ-015 SHALL have port func_color  in  NUM_FUNC*COLOR_W  flattened colours, function i at bits [i*COLOR_W +: COLOR_W].
REQ-016 SHALL have port func_addr  out  ADDR_W  registered address broadcast to all functions.
REQ-017 SHALL have port func_en  out  NUM_FUNC  registered one-hot enable of the function owning func_addr.
REQ-018 SHALL have port display_color  out  COLOR_W  registered colour to DAC.
REQ-019 SHALL have port active_func  out  SEL_W  currently committed function.
REQ-020 SHALL have port switching  out  1  high in PENDING or BLANK.

Function
REQ-021 FSM SHALL have states IDLE, PENDING, BLANK.
REQ-022 IDLE: req_valid with req_func < NUM_FUNC and != active_func SHALL latch req_func, go PENDING.
REQ-023 IDLE: req_valid with req_func >= NUM_FUNC SHALL pulse req_err next cycle, stay IDLE, no state change.
REQ-024 IDLE: req_valid with req_func == active_func SHALL be accepted as no-op, stay IDLE, no blanking.
REQ-025 req_valid outside IDLE SHALL be ignored, no req_err.
REQ-026 PENDING: on frame_start SHALL commit active_func <= latched index, load blank counter with BLANK_FRAMES, go BLANK; if BLANK_FRAMES == 0 go IDLE directly.
REQ-027 frame_start coincident with the accepting req_valid in IDLE SHALL NOT commit; commit waits for next frame_start.
REQ-028 BLANK: each frame_start SHALL decrement counter; transition to IDLE on the frame_start that makes it zero.
REQ-029 Address pipeline stage 1 (one cycle): func_addr <= display_addr, func_en <= addr_valid ? onehot(active_func) : 0, registered sel and valid copies.
REQ-030 Colour stage 2 (one cycle later): display_color <= stage-1 valid and not blanking ? func_color slice selected by stage-1 sel : 0.
REQ-031 Total latency display_addr -> display_color SHALL be exactly 2 cycles; sel used for colour SHALL be the one that issued the address.
REQ-032 "Blanking" in REQ-030 SHALL be state==BLANK sampled at stage 1; display_color SHALL be 0 for entire blank frames.
REQ-033 active_func SHALL change only on a committing frame_start, never mid-frame.

Reset
REQ-034 While rst high: state IDLE, active_func 0, func_addr 0, func_en 0, display_color 0, req_err 0, switching 0, req_ready 1, pipeline valids 0, blank counter 0.
REQ-035 rst asserted mid-PENDING or mid-BLANK SHALL abandon the switch; after release active_func 0 and first valid colour appears 2 cycles after first addr_valid.

Verification
REQ-036 Reset: rst pulse then addr_valid=1, addr=0x00010, func_color slice0=3'b101 -> func_addr=0x00010, func_en=4'b0001 at +1, display_color=3'b101 at +2.
REQ-037 Switch 0->2, BLANK_FRAMES=1: req at mid-frame -> active_func stays 0 until next frame_start, then 2; that whole frame display_color=0; following frame shows slice2.
REQ-038 req_func=3 with NUM_FUNC=3 -> req_err one cycle high, req_ready stays 1, active_func unchanged.
REQ-039 req_valid and frame_start in same cycle (IDLE, 0->1) -> no commit that cycle; commit on next frame_start; req_valid during PENDING ignored.
REQ-040 Address stream with commit mid-stream -> every display_color equals func_color slice of the function whose func_en bit issued its address 1 cycle earlier; no mixed-source pixel.
REQ-041 rst during BLANK -> active_func=0, switching=0, req_ready=1 immediately; colours resume from function 0.
